uart_frame_loader: RTL and testbench
====================================

UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

Interface
REQ-001 The block SHALL have parameter H_RES, default 160, horizontal pixels per frame.
REQ-002 The block SHALL have parameter V_RES, default 120, vertical lines per frame.
REQ-003 The block SHALL have parameter PIX_W, default 8, stored bits per pixel (1..8).
REQ-004 The block SHALL have parameter SYNC_BYTE, default 8'hAA, frame start marker.
REQ-005 The block SHALL have parameter DOUBLE_BUF, default 1, where 1 means two frame buffers and 0 means one.
REQ-006 The block SHALL have parameter TIMEOUT_CYC, default 5000000, maximum clk cycles allowed between bytes inside a frame.
REQ-007 The block SHALL derive N = H_RES*V_RES and ADDR_W = clog2(N) as local constants.
REQ-008 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-009 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-010 The block SHALL have port i_DV, input, 1 bit: one-cycle byte-valid strobe from the UART receiver.
REQ-011 The block SHALL have port i_byte, input, 8 bits: received byte, sampled when i_DV=1.
REQ-012 The block SHALL have port rd_addr, input, ADDR_W bits: display read address.
REQ-013 The block SHALL have port rd_pixel, output, PIX_W bits: front-buffer pixel data.
REQ-014 The block SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-015 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame is accepted.
REQ-016 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on checksum error or timeout.
REQ-017 The block SHALL have port front_sel, output, 1 bit: index of the buffer currently displayed.

Function
REQ-018 The FSM SHALL have three states: IDLE, LOAD, CHECK.
REQ-019 In IDLE, i_DV=1 with i_byte==SYNC_BYTE SHALL cause a transition to LOAD with wr_addr=0 and csum=0; any other byte SHALL be ignored.
REQ-020 In LOAD, each i_DV SHALL write i_byte[PIX_W-1:0] to the back buffer at wr_addr, update csum to csum XOR i_byte (all 8 bits), and increment wr_addr.
REQ-021 A SYNC_BYTE value received in LOAD SHALL be treated as pixel data and SHALL NOT restart the frame.
REQ-022 The write at wr_addr==N-1 SHALL move the FSM to CHECK; wr_addr SHALL never exceed N-1.
REQ-023 In CHECK, the next i_DV byte SHALL be compared with csum; on a match, frame_done SHALL pulse on the following cycle, otherwise frame_err SHALL pulse; the FSM SHALL then return to IDLE.
REQ-024 On frame_done with DOUBLE_BUF=1, front_sel SHALL toggle in the same cycle frame_done is asserted.
REQ-025 On frame_err, front_sel SHALL NOT change.
REQ-026 With DOUBLE_BUF=0, writes SHALL go directly to the single buffer and front_sel SHALL remain 0.
REQ-027 In LOAD and CHECK, an idle counter SHALL reset on every i_DV and increment otherwise.
REQ-028 When the idle counter reaches TIMEOUT_CYC, the block SHALL pulse frame_err and return to IDLE.
REQ-029 If i_DV coincides with the timeout cycle, i_DV SHALL take precedence and no timeout SHALL occur.
REQ-030 The idle counter SHALL NOT run in IDLE.
REQ-031 rd_pixel SHALL be registered, with exactly 1-cycle latency from rd_addr, reading the buffer selected by front_sel.
REQ-032 rd_addr >= N SHALL return rd_pixel=0.
REQ-033 The read port SHALL be independent of write activity; a read of an address in the same cycle as its write to the back buffer SHALL return the front-buffer value.
REQ-034 With DOUBLE_BUF=0, a same-address read and write in the same cycle SHALL return the old data.

Reset
REQ-035 rst=1 SHALL force, asynchronously: state=IDLE, wr_addr=0, csum=0, idle counter=0, front_sel=0, busy=0, frame_done=0, frame_err=0, rd_pixel=0.
REQ-036 Buffer memory contents SHALL NOT be cleared by reset.
REQ-037 Reset asserted mid-LOAD SHALL abandon the frame without any frame_done or frame_err pulse.

Verification (H_RES=4, V_RES=2, N=8, PIX_W=8, TIMEOUT_CYC=50)
REQ-038 The bench SHALL send AA, 01..08, checksum 08 -> frame_done pulses once, front_sel goes 0->1, and a read of rd_addr=5 returns 06 one cycle later.
REQ-039 The bench SHALL send AA, 01..08, checksum 00 -> frame_err pulses, front_sel stays unchanged, and the old frame remains readable.
REQ-040 The bench SHALL send 55, 13, then AA and a valid frame -> the 55 and 13 are ignored and the frame is accepted.
REQ-041 The bench SHALL send AA and 3 pixels, then idle 50 cycles -> frame_err pulses at the timeout, busy=0, and a following valid frame is accepted.
REQ-042 The bench SHALL assert rst after AA and 4 pixels -> busy=0 immediately, no pulse occurs, and front_sel=0.
REQ-043 With DOUBLE_BUF=0, the bench SHALL send a valid frame while reading address 2 -> rd_pixel tracks the new data as written and front_sel stays 0.

Source files
------------

// File: rtl/uart_frame_loader.sv
// Frame loader fed by a UART byte stream: sync byte, N pixel bytes, XOR checksum.
// Accepted frames swap the display buffer; the read port is registered, 1-cycle latency.
module uart_frame_loader #(
  parameter int          H_RES       = 160,
  parameter int          V_RES       = 120,
  parameter int          PIX_W       = 8,
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int          DOUBLE_BUF  = 1,
  parameter int          TIMEOUT_CYC = 5000000,
  localparam int         N           = H_RES * V_RES,
  localparam int         ADDR_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_DV,
  input  logic [7:0]        i_byte,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_pixel,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic              front_sel
);

  localparam int                CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Handshake: i_DV is a single-cycle strobe; i_byte is only meaningful while it is high.
  // There is no back-pressure, so every strobe is consumed in the cycle it arrives.

  state_t              state_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [7:0]          csum_q;
  logic [CNT_W-1:0]    idle_q;
  logic                front_sel_q;
  logic                done_q;
  logic                err_q;
  logic [PIX_W-1:0]    rd_pixel_q;

  logic                wr_en;
  logic [PIX_W-1:0]    wr_pix;
  logic                timeout;
  logic [31:0]         rd_addr_ext;
  logic                rd_in_range;
  logic [PIX_W-1:0]    rd_mem;

  assign wr_en       = (state_q == LOAD) && i_DV;
  assign wr_pix      = i_byte[PIX_W-1:0];
  assign timeout     = (idle_q == IDLE_LAST);
  assign rd_addr_ext = 32'(rd_addr);
  assign rd_in_range = (rd_addr_ext < 32'(N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      csum_q      <= '0;
      idle_q      <= '0;
      front_sel_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          idle_q <= '0;
          if (i_DV && (i_byte == SYNC_BYTE)) begin
            state_q   <= LOAD;
            wr_addr_q <= '0;
            csum_q    <= '0;
          end
        end
        LOAD: begin
          // A byte arriving on the timeout cycle wins over the timeout.
          if (i_DV) begin
            idle_q <= '0;
            csum_q <= csum_q ^ i_byte;
            if (wr_addr_q == LAST_ADDR) begin
              state_q <= CHECK;
            end else begin
              wr_addr_q <= wr_addr_q + ADDR_ONE;
            end
          end else if (timeout) begin
            idle_q  <= '0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            idle_q <= idle_q + CNT_ONE;
          end
        end
        CHECK: begin
          if (i_DV) begin
            idle_q  <= '0;
            state_q <= IDLE;
            if (i_byte == csum_q) begin
              done_q <= 1'b1;
              if (DOUBLE_BUF != 0) begin
                front_sel_q <= ~front_sel_q;
              end
            end else begin
              err_q <= 1'b1;
            end
          end else if (timeout) begin
            idle_q  <= '0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            idle_q <= idle_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          idle_q  <= '0;
        end
      endcase
    end
  end

  // Buffer storage is never reset; the back buffer is whichever one is not on display.
  if (DOUBLE_BUF != 0) begin : g_dbl
    logic [PIX_W-1:0] mem0 [N];
    logic [PIX_W-1:0] mem1 [N];

    always_ff @(posedge clk) begin
      if (wr_en) begin
        if (front_sel_q) begin
          mem0[wr_addr_q] <= wr_pix;
        end else begin
          mem1[wr_addr_q] <= wr_pix;
        end
      end
    end

    assign rd_mem = front_sel_q ? mem1[rd_addr] : mem0[rd_addr];
  end else begin : g_sgl
    logic [PIX_W-1:0] mem0 [N];

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem0[wr_addr_q] <= wr_pix;
      end
    end

    assign rd_mem = mem0[rd_addr];
  end

  // The read samples memory before the same-edge write lands, so it returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pixel_q <= '0;
    end else begin
      rd_pixel_q <= rd_in_range ? rd_mem : '0;
    end
  end

  assign rd_pixel   = rd_pixel_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign front_sel  = front_sel_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: random frames against a buffer/checksum model,
// frame events and reads checked by monitors through expected queues.
module tb_uart_frame_loader;

  localparam int N = 8;

  logic       clk;
  logic       rst;
  logic       i_dv;
  logic [7:0] i_byte;
  logic [2:0] rd_addr;
  logic [7:0] rd_pixel;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic       front_sel;

  logic       sb_dv;
  logic [7:0] sb_byte;
  logic [2:0] sb_rd_addr;
  logic [7:0] sb_rd_pixel;
  logic       sb_busy;
  logic       sb_done;
  logic       sb_err;
  logic       sb_front_sel;

  int n_checks;
  int n_pass;
  int sb_done_cnt;
  int sb_err_cnt;

  // Reference model: both buffer contents and the displayed index.
  logic [7:0] bufm [2][N];
  logic       m_front;
  logic [7:0] fr [N];

  logic [3:0] ev_q [$];
  logic [7:0] rd_q [$];
  logic       rd_chk;
  logic       rd_pend;

  uart_frame_loader #(
    .H_RES(4), .V_RES(2), .PIX_W(8), .SYNC_BYTE(8'hAA),
    .DOUBLE_BUF(1), .TIMEOUT_CYC(50)
  ) u_db (
    .clk(clk), .rst(rst), .i_DV(i_dv), .i_byte(i_byte), .rd_addr(rd_addr),
    .rd_pixel(rd_pixel), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .front_sel(front_sel)
  );

  uart_frame_loader #(
    .H_RES(4), .V_RES(2), .PIX_W(8), .SYNC_BYTE(8'hAA),
    .DOUBLE_BUF(0), .TIMEOUT_CYC(50)
  ) u_sb (
    .clk(clk), .rst(rst), .i_DV(sb_dv), .i_byte(sb_byte), .rd_addr(sb_rd_addr),
    .rd_pixel(sb_rd_pixel), .busy(sb_busy), .frame_done(sb_done),
    .frame_err(sb_err), .front_sel(sb_front_sel)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (frame_done || frame_err) begin
      if (ev_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: done=%0b err=%0b expected no event", frame_done, frame_err);
      end else begin
        chk("frame_event{done,err,front,busy}", {28'd0, frame_done, frame_err, front_sel, busy},
            {28'd0, ev_q.pop_front()});
      end
    end
  end

  always @(posedge clk) rd_pend <= rd_chk;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_pixel: got %0h expected nothing queued", rd_pixel);
      end else begin
        chk("rd_pixel", {24'd0, rd_pixel}, {24'd0, rd_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (sb_done) sb_done_cnt++;
    if (sb_err)  sb_err_cnt++;
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    i_byte = b;
    i_dv   = 1'b1;
    @(posedge clk); #1;
    i_dv   = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (ev_q.size() != 0 && k < 10) begin @(posedge clk); #1; k++; end
    chk("event_drain_pending", ev_q.size(), 0);
  endtask

  // mode 0: correct checksum, 1: random wrong checksum, 2: use ck_in
  task automatic send_frame(input int mode, input logic [7:0] ck_in, input int maxgap);
    logic [7:0] cs;
    logic [7:0] ck;
    logic       good;
    int         back;
    back = m_front ? 0 : 1;
    send_byte(8'hAA, $urandom_range(0, maxgap));
    cs = 8'h00;
    for (int i = 0; i < N; i++) begin
      bufm[back][i] = fr[i];
      cs = cs ^ fr[i];
      send_byte(fr[i], $urandom_range(0, maxgap));
    end
    if (mode == 0)      ck = cs;
    else if (mode == 1) ck = cs ^ 8'($urandom_range(1, 255));
    else                ck = ck_in;
    good = (ck == cs);
    if (good) m_front = ~m_front;
    ev_q.push_back({good, ~good, m_front, 1'b0});
    send_byte(ck, 0);
    drain();
  endtask

  task automatic rd(input logic [2:0] a);
    rd_q.push_back(bufm[m_front][a]);
    rd_addr = a;
    rd_chk  = 1'b1;
    @(posedge clk); #1;
    rd_chk  = 1'b0;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) fr[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic sb_send(input logic [7:0] b);
    sb_byte = b;
    sb_dv   = 1'b1;
    @(posedge clk); #1;
    sb_dv   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] sp [N];
    logic [7:0] cs;
    int         k;
    int         back;

    n_checks = 0; n_pass = 0; sb_done_cnt = 0; sb_err_cnt = 0;
    rst = 1'b1; i_dv = 1'b0; i_byte = 8'h00; rd_addr = 3'd0; rd_chk = 1'b0;
    sb_dv = 1'b0; sb_byte = 8'h00; sb_rd_addr = 3'd2;
    m_front = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_front_sel", front_sel, 0);
    chk("reset_rd_pixel", rd_pixel, 0);
    chk("reset_sb_busy", sb_busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known frame 01..08 with correct checksum 08
    for (int i = 0; i < N; i++) fr[i] = 8'(i + 1);
    send_frame(2, 8'h08, 0);
    chk("front_sel_after_first_frame", front_sel, 1);
    rd(3'd5);

    // Same frame with bad checksum 00: old frame stays on display
    send_frame(2, 8'h00, 1);
    chk("front_sel_after_bad_frame", front_sel, 1);
    for (int i = 0; i < N; i++) rd(3'(i));

    // Junk before sync is ignored; SYNC value inside the frame is pixel data
    send_byte(8'h55, 1);
    send_byte(8'h13, 1);
    chk("busy_after_junk", busy, 0);
    rand_frame();
    fr[3] = 8'hAA;
    send_frame(0, 8'h00, 2);
    for (int i = 0; i < N; i++) rd(3'(i));

    // Timeout after three pixels
    back = m_front ? 0 : 1;
    send_byte(8'hAA, 0);
    for (int i = 0; i < 3; i++) begin
      fr[i] = 8'($urandom_range(0, 255));
      bufm[back][i] = fr[i];
      send_byte(fr[i], 0);
    end
    ev_q.push_back({1'b0, 1'b1, m_front, 1'b0});
    k = 0;
    while (!frame_err && k < 70) begin @(posedge clk); #1; k++; end
    chk("timeout_idle_cycles", k, 50);
    chk("busy_after_timeout", busy, 0);
    drain();
    rand_frame();
    send_frame(0, 8'h00, 1);
    rd(3'($urandom_range(0, 7)));

    // Randomized frames with random gaps and checksum correctness
    for (int f = 0; f < 8; f++) begin
      rand_frame();
      send_frame(($urandom_range(0, 2) == 0) ? 1 : 0, 8'h00, 3);
      for (int r = 0; r < 3; r++) rd(3'($urandom_range(0, 7)));
    end

    // Reset mid-load: frame abandoned, no pulse, display back to buffer 0
    back = m_front ? 0 : 1;
    send_byte(8'hAA, 0);
    for (int i = 0; i < 4; i++) begin
      fr[i] = 8'($urandom_range(0, 255));
      bufm[back][i] = fr[i];
      send_byte(fr[i], 1);
    end
    rst = 1'b1;
    #1;
    chk("midload_rst_busy", busy, 0);
    chk("midload_rst_front_sel", front_sel, 0);
    chk("midload_rst_frame_done", frame_done, 0);
    chk("midload_rst_frame_err", frame_err, 0);
    m_front = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < N; i++) rd(3'(i));
    rand_frame();
    send_frame(0, 8'h00, 1);
    for (int i = 0; i < N; i++) rd(3'(i));

    // Single-buffer instance: reads follow writes directly
    cs = 8'h00;
    sb_send(8'hAA);
    for (int i = 0; i < N; i++) begin
      sb_send(8'(8'h10 + i));
      cs = cs ^ 8'(8'h10 + i);
    end
    sb_send(cs);
    repeat (2) begin @(posedge clk); #1; end
    chk("sb_done_count_1", sb_done_cnt, 1);
    chk("sb_rd_pixel_frame1", sb_rd_pixel, 8'h12);

    for (int i = 0; i < N; i++) sp[i] = 8'($urandom_range(0, 255));
    sp[2] = 8'h12 ^ 8'($urandom_range(1, 255));
    cs = 8'h00;
    sb_send(8'hAA);
    for (int i = 0; i < N; i++) begin
      cs = cs ^ sp[i];
      sb_send(sp[i]);
      if (i == 2) begin
        chk("sb_same_cycle_old_data", sb_rd_pixel, 8'h12);
        @(posedge clk); #1;
        chk("sb_tracks_new_data", sb_rd_pixel, sp[2]);
      end
    end
    sb_send(cs);
    repeat (2) begin @(posedge clk); #1; end
    chk("sb_done_count_2", sb_done_cnt, 2);
    chk("sb_err_count", sb_err_cnt, 0);
    chk("sb_front_sel", sb_front_sel, 0);
    chk("sb_rd_pixel_frame2", sb_rd_pixel, sp[2]);

    repeat (3) begin @(posedge clk); #1; end
    chk("events_left", ev_q.size(), 0);
    chk("reads_left", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
